tag_lookup_ctrl: RTL and testbench
==================================

Name: tag_lookup_ctrl

Overview:
Lookup/refill controller that drives the 64-set x 8-way tag array (tag_array_64x184) and consumes its read data.
- Accepts lookup requests, issues the array read, compares all 8 ways, and returns hit, hit-way and replacement victim.
- Owns per-set tree-PLRU state, serialises refill writes, and invalidates the whole array after reset.
- Sits between the cache request pipeline and the tag array macro.

Parameters:
SETS, 64, number of sets; address width is log2(SETS) = 6.
WAYS, 8, number of ways; fixed at 8 for the 7-bit tree PLRU.
TAG_W, 22, tag bits per way; each way entry is TAG_W+1 = 23 bits, so a row is WAYS*23 = 184 bits.

Ports:
clock  in  1  single clock for all logic and both array ports
reset  in  1  synchronous, active-high
req_valid  in  1  lookup request valid
req_ready  out  1  lookup accepted when req_valid && req_ready
req_set  in  6  lookup set index
req_tag  in  22  lookup tag
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_hit  out  1  a valid way matched the request tag
resp_way  out  8  one-hot hit way; 0 on miss
resp_victim  out  3  way to replace; the lowest invalid way, else the PLRU way
fill_valid  in  1  refill request valid
fill_ready  out  1  refill accepted when fill_valid && fill_ready
fill_set  in  6  refill set
fill_way  in  3  refill way
fill_tag  in  22  refill tag
ta_R0_addr  out  6  array read address
ta_R0_en  out  1  array read enable
ta_R0_data  in  184  array read data, valid one cycle after ta_R0_en
ta_W0_addr  out  6  array write address; the array registers it, so it applies to the write in the following cycle
ta_W0_en  out  1  array write enable
ta_W0_data  out  184  array write data
ta_W0_mask  out  8  per-way write mask

Behaviour:
- Way w entry is row bits [23w+22 : 23w]. Bit 22 of the entry is valid; bits 21:0 are the tag.
- Array clocks (R0_clk, W0_clk) are tied to clock outside this block.
- Reset values: req_ready=0, fill_ready=0, resp_valid=0, ta_R0_en=0, ta_W0_en=0, ta_W0_mask=0, all PLRU bits 0, FSM=INIT, outstanding count 0.
- FSM states are INIT, IDLE, FILL_ADDR and FILL_WR.
- INIT (invalidation sweep):
  - Cycle 0 after reset deasserts: ta_W0_addr=0, ta_W0_en=0.
  - Cycles 1..64: ta_W0_en=1, ta_W0_mask=8'hFF, ta_W0_data=0; ta_W0_addr leads by one cycle (cycle k drives addr k, write k-1 lands).
  - Then go to IDLE. Requests and fills are not accepted in INIT.
- Lookup pipeline:
  - Accept in cycle N: ta_R0_en=1, ta_R0_addr=req_set; stage S1 holds set and tag.
  - Cycle N+1: compare every way as valid && tag==req_tag, compute the victim, update PLRU on a hit, push the result into a 2-entry response FIFO.
  - resp_valid asserts no earlier than N+2. Responses stay in order.
  - ta_R0_en is driven only on accept, never on a stall.
- req_ready = (FSM==IDLE) && !fill_valid_pending && (S1_valid + fifo_count - pop) < 2, where pop = resp_valid && resp_ready.
  - With resp_ready held high this gives one lookup per cycle.
  - Responses are never dropped or duplicated.
- Fill:
  - fill_ready = (FSM==IDLE) && !S1_valid. Fill has priority over req_valid in the same cycle.
  - Accept moves the FSM to FILL_ADDR. This cycle drives ta_W0_addr=fill_set, en=0, and latches way and tag.
  - FILL_WR: ta_W0_en=1, ta_W0_mask=1<<way, ta_W0_data={{1,tag} replicated 8 times}. Update PLRU for that way, then go to IDLE.
  - Lookups are blocked from fill accept through FILL_WR, so no read/write hazard on the same set.
- PLRU, 7 bits per set:
  - b0 is the root (0 selects ways 0-3); b1/b2 are level 2; b3..b6 are leaves.
  - Victim: follow the bits down from the root.
  - On an access to way w, set each node on the path to point away from w.
  - A hit with resp_ready low still updates PLRU at compare time.
- Multi-hit never occurs (guaranteed by the cache). If it does, resp_way reports all matches and the PLRU update uses the lowest matching way.
- Reset mid-operation: the FSM returns to INIT, the FIFO and S1 are flushed, any in-flight write is suppressed, and the sweep restarts.

Decomposition:
- Package tag_lookup_pkg holds:
  - constants SETS, WAYS, TAG_W, ENTRY_W=23, ROW_W=184;
  - typedef tag_entry_t {valid, tag};
  - FSM enum;
  - functions plru_victim and plru_update.
- One sub-module: tag_lookup_resp_fifo (2-entry, valid/ready, synchronous reset).

Test Plan:
1. Release reset -> req_ready=0 for 65 cycles; 64 writes with mask 8'hFF and data 0 at addresses 0..63. Then lookup set 5 tag 22'h1234 -> resp_hit=0, resp_way=0, resp_victim=0.
2. Fill set 5 way 3 tag 22'h1234:
   - Expected writes: ta_W0_addr=5 in cycle N; ta_W0_en=1, mask=8'h08 in N+1; row bits [91:69]=23'h401234.
   - Follow-up lookup -> resp_hit=1, resp_way=8'h08.
3. Four back-to-back lookups with resp_ready=1 -> accepted one per cycle; responses in order, each 2 cycles after its accept.
4. Hold resp_ready=0 for 6 cycles while req_valid=1 -> req_ready drops after 2 outstanding. Release -> every response is delivered exactly once, in order.
5. Fill all 8 ways of set 9, then hit ways 0..7 in order -> next miss on set 9 gives resp_victim=0. Then hit way 0 -> victim=4.
6. Assert reset in the FILL_ADDR cycle -> ta_W0_en=0 with mask 8'h08 never issued. The INIT sweep restarts; a lookup after INIT misses.

Source files
------------

// File: rtl/tag_lookup_pkg.sv
`default_nettype none
// tag_lookup_pkg: shared constants, types and tree-PLRU helpers for the tag lookup controller.
// Rev 1.0
package tag_lookup_pkg;

  localparam int SETS    = 64;
  localparam int WAYS    = 8;
  localparam int TAG_W   = 22;
  localparam int SET_W   = $clog2(SETS);
  localparam int ENTRY_W = TAG_W + 1;
  localparam int ROW_W   = WAYS * ENTRY_W;
  localparam int PLRU_W  = WAYS - 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    FILL_ADDR = 2'd2,
    FILL_WR   = 2'd3
  } state_t;

  typedef struct packed {
    logic            hit;
    logic [WAYS-1:0] way;
    logic [2:0]      victim;
  } resp_t;

  // b0 is the root, b1/b2 the second level, b3..b6 the leaves (ways 0/1 .. 6/7).
  function automatic logic [2:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [2:0] w;
    w[2] = bits[0];
    w[1] = w[2] ? bits[2] : bits[1];
    case ({w[2], w[1]})
      2'b00:   w[0] = bits[3];
      2'b01:   w[0] = bits[4];
      2'b10:   w[0] = bits[5];
      default: w[0] = bits[6];
    endcase
    return w;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] bits,
                                                    input logic [2:0]        way);
    logic [PLRU_W-1:0] n;
    n    = bits;
    n[0] = ~way[2];
    if (way[2]) n[2] = ~way[1];
    else        n[1] = ~way[1];
    case (way[2:1])
      2'b00:   n[3] = ~way[0];
      2'b01:   n[4] = ~way[0];
      2'b10:   n[5] = ~way[0];
      default: n[6] = ~way[0];
    endcase
    return n;
  endfunction

  function automatic logic [2:0] lowest_way(input logic [WAYS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_lookup_resp_fifo.sv
`default_nettype none
// tag_lookup_resp_fifo: 2-entry in-order response FIFO between the compare stage and the requester.
// Rev 1.0
module tag_lookup_resp_fifo
  import tag_lookup_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  resp_t      in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output resp_t      out_data,
  output logic [1:0] count
);

  resp_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  push;
  logic  pop;

  // The controller only launches a lookup when this FIFO is certain to have room.
  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/tag_lookup_ctrl.sv
`default_nettype none
// tag_lookup_ctrl: lookup/refill controller for the 64-set x 8-way tag array with per-set tree PLRU.
// Rev 1.0
module tag_lookup_ctrl
  import tag_lookup_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SET_W-1:0]   req_set,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [WAYS-1:0]    resp_way,
  output logic [2:0]         resp_victim,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [SET_W-1:0]   fill_set,
  input  logic [2:0]         fill_way,
  input  logic [TAG_W-1:0]   fill_tag,
  output logic [SET_W-1:0]   ta_R0_addr,
  output logic               ta_R0_en,
  input  logic [ROW_W-1:0]   ta_R0_data,
  output logic [SET_W-1:0]   ta_W0_addr,
  output logic               ta_W0_en,
  output logic [ROW_W-1:0]   ta_W0_data,
  output logic [WAYS-1:0]    ta_W0_mask
);

  state_t             state;
  logic [6:0]         init_cnt;
  logic [PLRU_W-1:0]  plru [SETS];
  logic               s1_valid;
  logic [SET_W-1:0]   s1_set;
  logic [TAG_W-1:0]   s1_tag;
  logic [SET_W-1:0]   fill_set_q;
  logic [2:0]         fill_way_q;
  logic [TAG_W-1:0]   fill_tag_q;

  logic [1:0]         fifo_count;
  resp_t              fifo_out;
  resp_t              push_data;
  logic               pop;
  logic [2:0]         occupancy;
  logic               req_accept;
  logic               fill_accept;
  logic [WAYS-1:0]    match;
  logic [WAYS-1:0]    invalid;
  logic               hit;
  logic [2:0]         hit_way;
  logic [2:0]         victim;

  assign pop         = resp_valid && resp_ready;
  assign occupancy   = {2'b00, s1_valid} + {1'b0, fifo_count} - {2'b00, pop};
  assign req_ready   = (state == IDLE) && !fill_valid && (occupancy < 3'd2);
  assign fill_ready  = (state == IDLE) && !s1_valid;
  assign req_accept  = req_valid && req_ready;
  assign fill_accept = fill_valid && fill_ready;
  assign ta_R0_en    = req_accept;
  assign ta_R0_addr  = req_set;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    tag_entry_t entry;
    assign entry      = ta_R0_data[g*ENTRY_W +: ENTRY_W];
    assign match[g]   = entry.valid && (entry.tag == s1_tag);
    assign invalid[g] = !entry.valid;
  end

  // Multi-hit is not expected; the lowest matching way steers the PLRU if it happens.
  assign hit       = |match;
  assign hit_way   = lowest_way(match);
  assign victim    = (|invalid) ? lowest_way(invalid) : plru_victim(plru[s1_set]);
  assign push_data = {hit, match, victim};

  tag_lookup_resp_fifo u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_data   (push_data),
    .out_valid (resp_valid),
    .out_ready (resp_ready),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign resp_hit    = fifo_out.hit;
  assign resp_way    = fifo_out.way;
  assign resp_victim = fifo_out.victim;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      s1_valid   <= 1'b0;
      ta_W0_addr <= '0;
      ta_W0_en   <= 1'b0;
      ta_W0_mask <= '0;
      ta_W0_data <= '0;
      fill_set_q <= '0;
      fill_way_q <= '0;
      fill_tag_q <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      s1_valid <= req_accept;
      if (req_accept) begin
        s1_set <= req_set;
        s1_tag <= req_tag;
      end
      if (s1_valid && hit) plru[s1_set] <= plru_update(plru[s1_set], hit_way);

      case (state)
        // The array registers the write address, so the address runs one row ahead of the enable.
        INIT: begin
          init_cnt <= init_cnt + 7'd1;
          if (init_cnt == 7'(SETS)) begin
            state      <= IDLE;
            ta_W0_en   <= 1'b0;
            ta_W0_mask <= '0;
          end else begin
            ta_W0_en   <= 1'b1;
            ta_W0_mask <= '1;
            ta_W0_data <= '0;
            ta_W0_addr <= init_cnt[SET_W-1:0] + 6'd1;
          end
        end
        IDLE: begin
          if (fill_accept) begin
            state      <= FILL_ADDR;
            ta_W0_addr <= fill_set;
            fill_set_q <= fill_set;
            fill_way_q <= fill_way;
            fill_tag_q <= fill_tag;
          end
        end
        FILL_ADDR: begin
          state      <= FILL_WR;
          ta_W0_en   <= 1'b1;
          ta_W0_mask <= WAYS'(1) << fill_way_q;
          ta_W0_data <= {WAYS{{1'b1, fill_tag_q}}};
        end
        default: begin
          state            <= IDLE;
          ta_W0_en         <= 1'b0;
          ta_W0_mask       <= '0;
          plru[fill_set_q] <= plru_update(plru[fill_set_q], fill_way_q);
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_lookup_ctrl.sv
`default_nettype none
// tb_tag_lookup_ctrl: directed self-checking bench with a behavioural tag array model.
// Rev 1.0
module tb_tag_lookup_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid, req_ready;
  logic [5:0]   req_set;
  logic [21:0]  req_tag;
  logic         resp_valid, resp_ready, resp_hit;
  logic [7:0]   resp_way;
  logic [2:0]   resp_victim;
  logic         fill_valid, fill_ready;
  logic [5:0]   fill_set;
  logic [2:0]   fill_way;
  logic [21:0]  fill_tag;
  logic [5:0]   ta_R0_addr, ta_W0_addr;
  logic         ta_R0_en, ta_W0_en;
  logic [183:0] ta_R0_data, ta_W0_data;
  logic [7:0]   ta_W0_mask;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  tag_lookup_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_victim(resp_victim),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
    .fill_way(fill_way), .fill_tag(fill_tag),
    .ta_R0_addr(ta_R0_addr), .ta_R0_en(ta_R0_en), .ta_R0_data(ta_R0_data),
    .ta_W0_addr(ta_W0_addr), .ta_W0_en(ta_W0_en), .ta_W0_data(ta_W0_data),
    .ta_W0_mask(ta_W0_mask)
  );

  // Array model: registered write address, masked write, one-cycle read latency.
  // Reset fills it with valid garbage so a missing invalidation shows up as a hit.
  logic [183:0] mem [64];
  logic [183:0] rd_q;
  logic [5:0]   waddr_q;
  logic [183:0] row;
  always @(posedge clock) begin
    waddr_q <= ta_W0_addr;
    if (reset) begin
      for (int s = 0; s < 64; s++) mem[s] <= {8{{1'b1, 22'h1234}}};
    end else if (ta_W0_en) begin
      row = mem[waddr_q];
      for (int w = 0; w < 8; w++) if (ta_W0_mask[w]) row[w*23 +: 23] = ta_W0_data[w*23 +: 23];
      mem[waddr_q] <= row;
    end
    if (ta_R0_en) rd_q <= mem[ta_R0_addr];
  end
  assign ta_R0_data = rd_q;

  typedef struct { int cyc; logic hit; logic [7:0] way; logic [2:0] victim; } resp_rec_t;
  typedef struct { logic [5:0] addr; logic [7:0] mask; logic [183:0] data; } wr_rec_t;
  resp_rec_t resp_q[$];
  wr_rec_t   wr_q[$];
  int        acc_q[$];

  always @(negedge clock) begin
    if (resp_valid && resp_ready) resp_q.push_back('{cyc_n, resp_hit, resp_way, resp_victim});
    if (ta_W0_en) wr_q.push_back('{waddr_q, ta_W0_mask, ta_W0_data});
    if (req_valid && req_ready) acc_q.push_back(cyc_n);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic issue_req(input logic [5:0] s, input logic [21:0] t, output bit ok);
    ok = 0;
    req_valid = 1; req_set = s; req_tag = t;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (req_ready) ok = 1;
      @(posedge clock); #1;
    end
    req_valid = 0;
  endtask

  task automatic wait_resp(output resp_rec_t r, output bit ok);
    ok = 0;
    r = '{default: 0};
    for (int i = 0; i < 50; i++) begin
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        ok = 1;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic do_fill(input logic [5:0] s, input logic [2:0] w, input logic [21:0] t,
                         output bit ok);
    ok = 0;
    fill_valid = 1; fill_set = s; fill_way = w; fill_tag = t;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (fill_ready) ok = 1;
      @(posedge clock); #1;
    end
    fill_valid = 0;
    repeat (2) begin @(posedge clock); #1; end
  endtask

  task automatic wait_idle(output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (req_ready) ok = 1;
      else n++;
    end
    @(posedge clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clock); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if (fill_ready !== 1'b0) begin errors++; $display("FAIL rst_fill_ready got %b exp 0", fill_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (ta_R0_en !== 1'b0) begin errors++; $display("FAIL rst_r0_en got %b exp 0", ta_R0_en); end
    checks++; if (ta_W0_en !== 1'b0) begin errors++; $display("FAIL rst_w0_en got %b exp 0", ta_W0_en); end
    checks++; if (ta_W0_mask !== 8'h00) begin errors++; $display("FAIL rst_w0_mask got %h exp 00", ta_W0_mask); end
  endtask

  task automatic test_init();
    int n; bit ok; int bad;
    wr_q.delete();
    reset = 0;
    wait_idle(n, ok);
    checks++; if (!ok || n != 65) begin errors++; $display("FAIL init_busy_cycles got %0d (ok=%0d) exp 65", n, ok); end
    checks++; if (wr_q.size() != 64) begin errors++; $display("FAIL init_write_count got %0d exp 64", wr_q.size()); end
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].addr != 6'(i) || wr_q[i].mask != 8'hFF || wr_q[i].data != '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL init_write_content got %0d bad exp 0", bad); end
  endtask

  task automatic test_miss();
    bit ok1, ok2; resp_rec_t r;
    resp_q.delete();
    issue_req(6'd5, 22'h1234, ok1);
    wait_resp(r, ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL miss_timeout got %0d%0d exp 11", ok1, ok2); end
    checks++; if (r.hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", r.hit); end
    checks++; if (r.way !== 8'h00) begin errors++; $display("FAIL miss_way got %h exp 00", r.way); end
    checks++; if (r.victim !== 3'd0) begin errors++; $display("FAIL miss_victim got %0d exp 0", r.victim); end
  endtask

  task automatic test_fill();
    bit ok; bit ok2; resp_rec_t r;
    resp_q.delete();
    fill_valid = 1; fill_set = 6'd5; fill_way = 3'd3; fill_tag = 22'h1234;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (fill_ready) ok = 1;
      @(posedge clock); #1;
    end
    fill_valid = 0;
    checks++; if (!ok) begin errors++; $display("FAIL fill_accept got 0 exp 1"); end
    checks++; if (ta_W0_addr !== 6'd5 || ta_W0_en !== 1'b0) begin
      errors++; $display("FAIL fill_addr_cycle got addr=%0d en=%b exp addr=5 en=0", ta_W0_addr, ta_W0_en); end
    @(posedge clock); #1;
    checks++; if (ta_W0_en !== 1'b1 || ta_W0_mask !== 8'h08) begin
      errors++; $display("FAIL fill_wr_cycle got en=%b mask=%h exp en=1 mask=08", ta_W0_en, ta_W0_mask); end
    checks++; if (ta_W0_data[91:69] !== 23'h401234) begin
      errors++; $display("FAIL fill_wr_data got %h exp 401234", ta_W0_data[91:69]); end
    @(posedge clock); #1;
    issue_req(6'd5, 22'h1234, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.hit !== 1'b1 || r.way !== 8'h08) begin
      errors++; $display("FAIL fill_hit got hit=%b way=%h exp hit=1 way=08", r.hit, r.way); end
    checks++; if (r.victim !== 3'd0) begin errors++; $display("FAIL fill_hit_victim got %0d exp 0", r.victim); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] tv [4] = '{22'h1234, 22'h0001, 22'h1234, 22'h2222};
    logic        eh [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int idx = 0;
    acc_q.delete(); resp_q.delete();
    resp_ready = 1; req_valid = 1; req_set = 6'd5; req_tag = tv[0];
    for (int g = 0; g < 50 && idx < 4; g++) begin
      @(negedge clock);
      if (req_ready) idx++;
      @(posedge clock); #1;
      if (idx < 4) req_tag = tv[idx];
    end
    req_valid = 0;
    for (int g = 0; g < 20 && resp_q.size() < 4; g++) begin @(posedge clock); #1; end
    checks++; if (acc_q.size() != 4 || resp_q.size() != 4) begin
      errors++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 4/4", acc_q.size(), resp_q.size()); end
    if (acc_q.size() == 4 && resp_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (acc_q[i] != acc_q[0] + i) begin
          errors++; $display("FAIL b2b_accept_rate[%0d] got cyc %0d exp %0d", i, acc_q[i], acc_q[0] + i); end
        checks++; if (resp_q[i].cyc != acc_q[i] + 2) begin
          errors++; $display("FAIL b2b_latency[%0d] got cyc %0d exp %0d", i, resp_q[i].cyc, acc_q[i] + 2); end
        checks++; if (resp_q[i].hit !== eh[i] || resp_q[i].way !== (eh[i] ? 8'h08 : 8'h00)) begin
          errors++; $display("FAIL b2b_result[%0d] got hit=%b way=%h exp hit=%b", i, resp_q[i].hit, resp_q[i].way, eh[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] tv [4] = '{22'h2222, 22'h1234, 22'h0333, 22'h1234};
    int idx = 0;
    acc_q.delete(); resp_q.delete();
    resp_ready = 0; req_valid = 1; req_set = 6'd5; req_tag = tv[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (req_ready) idx++;
      @(posedge clock); #1;
      if (idx < 4) req_tag = tv[idx];
    end
    #1;
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_accepts got %0d exp 2", acc_q.size()); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall got req_ready=%b resp_valid=%b exp 0/1", req_ready, resp_valid); end
    checks++; if (resp_q.size() != 0) begin errors++; $display("FAIL bp_no_pop got %0d exp 0", resp_q.size()); end
    req_valid = 0; resp_ready = 1;
    repeat (10) begin @(posedge clock); #1; end
    checks++; if (resp_q.size() != 2) begin errors++; $display("FAIL bp_delivered got %0d exp 2", resp_q.size()); end
    if (resp_q.size() == 2) begin
      checks++; if (resp_q[0].hit !== 1'b0 || resp_q[1].hit !== 1'b1 || resp_q[1].way !== 8'h08) begin
        errors++; $display("FAIL bp_order got hit0=%b hit1=%b way1=%h exp 0/1/08", resp_q[0].hit, resp_q[1].hit, resp_q[1].way); end
    end
  endtask

  task automatic test_plru();
    bit ok, ok2; resp_rec_t r; int fill_fail = 0;
    resp_q.delete();
    for (int w = 0; w < 8; w++) begin
      do_fill(6'd9, 3'(w), 22'(32'h100 + w), ok);
      if (!ok) fill_fail++;
    end
    checks++; if (fill_fail != 0) begin errors++; $display("FAIL plru_fills got %0d stuck exp 0", fill_fail); end
    for (int w = 0; w < 8; w++) begin
      issue_req(6'd9, 22'(32'h100 + w), ok);
      wait_resp(r, ok2);
      checks++; if (!ok || !ok2 || r.hit !== 1'b1 || r.way !== (8'(1) << w)) begin
        errors++; $display("FAIL plru_hit_way%0d got hit=%b way=%h exp way=%h", w, r.hit, r.way, 8'(1) << w); end
    end
    issue_req(6'd9, 22'h3abcd, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.hit !== 1'b0 || r.victim !== 3'd0) begin
      errors++; $display("FAIL plru_victim_after_sweep got hit=%b victim=%0d exp 0/0", r.hit, r.victim); end
    issue_req(6'd9, 22'h100, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.hit !== 1'b1 || r.way !== 8'h01) begin
      errors++; $display("FAIL plru_rehit_way0 got hit=%b way=%h exp 1/01", r.hit, r.way); end
    issue_req(6'd9, 22'h3abcd, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.victim !== 3'd4) begin
      errors++; $display("FAIL plru_victim_after_way0 got %0d exp 4", r.victim); end
  endtask

  task automatic test_reset_in_fill();
    bit ok, ok2; int n; int bad; resp_rec_t r;
    fill_valid = 1; fill_set = 6'd7; fill_way = 3'd3; fill_tag = 22'h0abc;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (fill_ready) ok = 1;
      @(posedge clock); #1;
    end
    fill_valid = 0;
    wr_q.delete();
    reset = 1;
    checks++; if (!ok) begin errors++; $display("FAIL rif_accept got 0 exp 1"); end
    @(posedge clock); #1;
    checks++; if (ta_W0_en !== 1'b0 || ta_W0_mask !== 8'h00) begin
      errors++; $display("FAIL rif_suppressed got en=%b mask=%h exp 0/00", ta_W0_en, ta_W0_mask); end
    repeat (2) begin @(posedge clock); #1; end
    reset = 0;
    wait_idle(n, ok);
    checks++; if (!ok || n != 65) begin errors++; $display("FAIL rif_busy_cycles got %0d exp 65", n); end
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].mask != 8'hFF || wr_q[i].data != '0) bad++;
    checks++; if (bad != 0 || wr_q.size() != 64) begin
      errors++; $display("FAIL rif_writes got %0d bad of %0d exp 0 of 64", bad, wr_q.size()); end
    resp_q.delete();
    issue_req(6'd7, 22'h0abc, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.hit !== 1'b0) begin errors++; $display("FAIL rif_miss_set7 got hit=%b exp 0", r.hit); end
    issue_req(6'd5, 22'h1234, ok);
    wait_resp(r, ok2);
    checks++; if (!ok || !ok2 || r.hit !== 1'b0 || r.victim !== 3'd0) begin
      errors++; $display("FAIL rif_miss_set5 got hit=%b victim=%0d exp 0/0", r.hit, r.victim); end
  endtask

  initial begin
    req_valid = 0; req_set = '0; req_tag = '0; resp_ready = 1;
    fill_valid = 0; fill_set = '0; fill_way = '0; fill_tag = '0;
    test_reset();
    test_init();
    test_miss();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_plru();
    test_reset_in_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
